// File: rtl/gpio_arbiter_pkg.sv
// Shared definitions for the two-master GPIO Wishbone arbiter:
// FSM encoding, master index constants and the timeout counter width.
package gpio_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int TMO_W = 16;

endpackage : gpio_arbiter_pkg

// File: rtl/gpio_arbiter_if.sv
// Wishbone signal bundle between two masters, the arbiter and the GPIO slave.
// The arbiter uses the slave modport; the environment driving it uses master.
interface gpio_arbiter_if;

   logic [31:0] m0_wb_dat_i;
   logic        m0_wb_we_i;
   logic [3:0]  m0_wb_sel_i;
   logic        m0_wb_stb_i;
   logic [31:0] m0_wb_dat_o;
   logic        m0_wb_ack_o;
   logic        m0_wb_err_o;

   logic [31:0] m1_wb_dat_i;
   logic        m1_wb_we_i;
   logic [3:0]  m1_wb_sel_i;
   logic        m1_wb_stb_i;
   logic [31:0] m1_wb_dat_o;
   logic        m1_wb_ack_o;
   logic        m1_wb_err_o;

   logic [31:0] s_wb_dat_o;
   logic        s_wb_we_o;
   logic [3:0]  s_wb_sel_o;
   logic        s_wb_stb_o;
   logic [31:0] s_wb_dat_i;
   logic        s_wb_ack_i;

   modport slave (
      input  m0_wb_dat_i, m0_wb_we_i, m0_wb_sel_i, m0_wb_stb_i,
      output m0_wb_dat_o, m0_wb_ack_o, m0_wb_err_o,
      input  m1_wb_dat_i, m1_wb_we_i, m1_wb_sel_i, m1_wb_stb_i,
      output m1_wb_dat_o, m1_wb_ack_o, m1_wb_err_o,
      output s_wb_dat_o, s_wb_we_o, s_wb_sel_o, s_wb_stb_o,
      input  s_wb_dat_i, s_wb_ack_i
   );

   modport master (
      output m0_wb_dat_i, m0_wb_we_i, m0_wb_sel_i, m0_wb_stb_i,
      input  m0_wb_dat_o, m0_wb_ack_o, m0_wb_err_o,
      output m1_wb_dat_i, m1_wb_we_i, m1_wb_sel_i, m1_wb_stb_i,
      input  m1_wb_dat_o, m1_wb_ack_o, m1_wb_err_o,
      input  s_wb_dat_o, s_wb_we_o, s_wb_sel_o, s_wb_stb_o,
      output s_wb_dat_i, s_wb_ack_i
   );

endinterface : gpio_arbiter_if

// File: rtl/gpio_rr_pick2.sv
// Two-way round-robin pick: a contested request goes to the master
// that was not granted last; a lone request is granted directly.
module gpio_rr_pick2
   import gpio_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == M1) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule : gpio_rr_pick2

// File: rtl/gpio_arbiter.sv
// Two-master to one-slave Wishbone arbiter for the GPIO block, IDLE/BUSY FSM.
// Optional ack timeout with error pulse enabled by macro GPIO_ARBITER_TIMEOUT_EN.
module gpio_arbiter
   import gpio_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   gpio_arbiter_if.slave   bus,
   output logic [1:0]      grant_o
);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic [1:0] req;
   logic [1:0] pick;
   logic       own_stb;
   logic       tmo_hit;

   assign req     = {bus.m1_wb_stb_i, bus.m0_wb_stb_i};
   assign own_stb = (owner_q == M1) ? bus.m1_wb_stb_i : bus.m0_wb_stb_i;

   gpio_rr_pick2 u_pick (
      .req  (req),
      .last (last_q),
      .gnt  (pick)
   );

`ifdef GPIO_ARBITER_TIMEOUT_EN
   logic [TMO_W-1:0] cnt_q;

   // Held at zero while idle so every BUSY period starts counting from 0.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)            cnt_q <= '0;
      else if (state_q == IDLE)  cnt_q <= '0;
      else                       cnt_q <= cnt_q + 1'b1;
   end

   assign tmo_hit = (state_q == BUSY) && (cnt_q == TMO_W'(TIMEOUT_CYCLES))
                    && !bus.s_wb_ack_i;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TMO_W'(TIMEOUT_CYCLES);
   assign tmo_hit        = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         owner_q <= M0;
         last_q  <= M1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (pick != 2'b00) begin
               state_d = BUSY;
               owner_d = pick[M1];
            end
         end
         BUSY: begin
            // Completion, abort and timeout all release the slave the same way.
            if (bus.s_wb_ack_i || !own_stb || tmo_hit) begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_o         = 2'b00;
      bus.s_wb_stb_o  = 1'b0;
      bus.s_wb_we_o   = 1'b0;
      bus.s_wb_sel_o  = 4'b0000;
      bus.s_wb_dat_o  = 32'h0;
      bus.m0_wb_dat_o = 32'h0;
      bus.m0_wb_ack_o = 1'b0;
      bus.m0_wb_err_o = 1'b0;
      bus.m1_wb_dat_o = 32'h0;
      bus.m1_wb_ack_o = 1'b0;
      bus.m1_wb_err_o = 1'b0;
      if (state_q == BUSY) begin
         bus.s_wb_stb_o = own_stb;
         if (owner_q == M1) begin
            grant_o         = 2'b10;
            bus.s_wb_we_o   = bus.m1_wb_we_i;
            bus.s_wb_sel_o  = bus.m1_wb_sel_i;
            bus.s_wb_dat_o  = bus.m1_wb_dat_i;
            bus.m1_wb_dat_o = bus.s_wb_dat_i;
            bus.m1_wb_ack_o = bus.s_wb_ack_i;
            bus.m1_wb_err_o = tmo_hit;
         end else begin
            grant_o         = 2'b01;
            bus.s_wb_we_o   = bus.m0_wb_we_i;
            bus.s_wb_sel_o  = bus.m0_wb_sel_i;
            bus.s_wb_dat_o  = bus.m0_wb_dat_i;
            bus.m0_wb_dat_o = bus.s_wb_dat_i;
            bus.m0_wb_ack_o = bus.s_wb_ack_i;
            bus.m0_wb_err_o = tmo_hit;
         end
      end
   end

endmodule : gpio_arbiter
